// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared sequencer states, RV32 OP-opcode and ALU control encodings
package rv_ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;
   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
endpackage

// File: rtl/r_type_sequencer_if.sv
// r_type_sequencer_if: fetch handshake and datapath control bundle; master = sequencer
interface r_type_sequencer_if;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        pc_inc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic [3:0]  alu_ctrl;
   logic        alu_en;
   logic        reg_write;
   logic        illegal;
   logic        busy;
   modport master (input run, imem_ack, imem_rdata,
                   output imem_req, pc_inc, rs1_addr, rs2_addr, rd_addr, alu_ctrl, alu_en, reg_write, illegal, busy);
   modport slave  (output run, imem_ack, imem_rdata,
                   input imem_req, pc_inc, rs1_addr, rs2_addr, rd_addr, alu_ctrl, alu_en, reg_write, illegal, busy);
endinterface

// File: rtl/r_type_decode.sv
// r_type_decode: combinational R-type field extraction and legality check of the instruction register
module r_type_decode
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic        legal,
   output logic [3:0]  alu_ctrl,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd
);
   assign legal    = ir[6:0] == OPC_OP &&
                     (ir[31:25] == F7_BASE || (ir[31:25] == F7_ALT && (ir[14:12] == 3'b000 || ir[14:12] == 3'b101)));
   assign alu_ctrl = {ir[30], ir[14:12]};
   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign rd       = ir[11:7];
endmodule

// File: rtl/r_type_sequencer.sv
// r_type_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control for R-type ops; RSEQ_RETIRE_CNT_EN adds retire_cnt
module r_type_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RETIRE_CNT_W = 32
)(
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef RSEQ_RETIRE_CNT_EN
   output logic [RETIRE_CNT_W-1:0] retire_cnt,
`endif
   r_type_sequencer_if.master      bus
);
   state_t          state, state_nx;
   logic [XLEN-1:0] ir;
   logic            legal;
   // field outputs come straight off the IR register, so they hold from DECODE through WRITEBACK
   r_type_decode u_dec (
      .ir       (ir),
      .legal    (legal),
      .alu_ctrl (bus.alu_ctrl),
      .rs1      (bus.rs1_addr),
      .rs2      (bus.rs2_addr),
      .rd       (bus.rd_addr)
   );
   // state register; async reset drops every Moore strobe at once
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   // instruction register loads only on an ack seen while fetching
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                              ir <= '0;
      else if (state == S_FETCH && bus.imem_ack) ir <= bus.imem_rdata;
   // next state and Moore outputs
   always_comb begin
      state_nx      = state;
      case (state)
         S_IDLE:      state_nx = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:     state_nx = bus.imem_ack ? S_DECODE : S_FETCH;
         S_DECODE:    state_nx = legal ? S_EXECUTE : S_IDLE;
         S_EXECUTE:   state_nx = S_WRITEBACK;
         S_WRITEBACK: state_nx = bus.run ? S_FETCH : S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
      bus.imem_req  = state == S_FETCH;
      bus.illegal   = state == S_DECODE && !legal;
      bus.alu_en    = state == S_EXECUTE;
      bus.pc_inc    = state == S_WRITEBACK;
      bus.reg_write = state == S_WRITEBACK && bus.rd_addr != 5'd0;
      bus.busy      = state != S_IDLE;
   end
`ifdef RSEQ_RETIRE_CNT_EN
   // one count per WRITEBACK; wraps naturally at all-ones
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                    retire_cnt <= '0;
      else if (state == S_WRITEBACK) retire_cnt <= retire_cnt + 1'b1;
`endif
endmodule
